seq_shift_unit: RTL and testbench
=================================

Name: seq_shift_unit

Overview:
- Multi-cycle shift unit that performs one bit position per clock.
- It sits as the sequential responder to the ALU's shift requests and accepts the same operand set as the combinational n-bit shifter: input word, direction, amount, logical/arithmetic select.
- Valid/ready handshakes are used on both the request side and the result side.
- Results must match the combinational shifter bit-for-bit, so either unit can be substituted for the other.

Parameters:
- WIDTH, 4, data width; also the width of shift_amt.
- CNT_WIDTH, 8, width of the completed-operation counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  request present.
- in_ready  output  1  unit can accept a request.
- in  input  WIDTH  operand.
- shift_dir  input  1  0 = left, 1 = right.
- op  input  1  0 = logical, 1 = arithmetic.
- shift_amt  input  WIDTH  number of bit positions to shift.
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes the result.
- out  output  WIDTH  result.
- busy  output  1  high whenever the state is not IDLE.
- op_count  output  CNT_WIDTH  number of completed result handshakes; wraps to 0 on overflow.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE; all internal registers cleared.
  - out = 0, out_valid = 0, busy = 0, op_count = 0; in_ready = 1 as soon as reset is asserted.
- States: IDLE, SHIFT, DONE.
  - in_ready = 1 only in IDLE.
  - out_valid = 1 only in DONE.
- IDLE:
  - Acceptance is on a rising edge with in_valid = 1.
  - On acceptance, capture in into the result register, and capture shift_dir and op.
  - Load cnt = min(shift_amt, WIDTH); amounts at or above WIDTH saturate to WIDTH.
  - If cnt = 0, go to DONE. Otherwise go to SHIFT.
- SHIFT: each edge performs one step:
  - Left: result = {result[WIDTH-2:0], 0}. op has no effect for left shifts.
  - Right, logical: result = {0, result[WIDTH-1:1]}.
  - Right, arithmetic: result = {result[WIDTH-1], result[WIDTH-1:1]}.
  - Decrement cnt on each step. On the edge where cnt = 1, perform the final step and go to DONE.
- DONE:
  - out_valid = 1 and out = result, both held stable until out_ready = 1 at an edge.
  - On that edge: op_count increments and the state returns to IDLE.
- Latency:
  - With k = saturated amount, out_valid rises k edges after the accepting edge.
  - k = 0 gives out_valid immediately after the accepting edge.
  - Throughput is one operation per k+2 cycles minimum (accept edge, k shift edges, handshake edge).
- Operand stability: in, shift_dir, op and shift_amt are sampled only at the accepting edge. Changes to them during SHIFT or DONE have no effect.
- in_valid outside IDLE is ignored; the request must be held by the requester until in_ready.
- out holds the last result through IDLE until the next accept overwrites the register.
- Simultaneous out_ready and in_valid in DONE: only the result handshake completes. The new request is accepted on the following edge in IDLE.
- Reset mid-operation: the operation is abandoned, no result is emitted, and op_count clears.
- Saturated results:
  - Logical shift by WIDTH gives 0.
  - Arithmetic right shift by WIDTH gives all bits equal to the original MSB.
- out_ready = 1 outside DONE has no effect.

Test Plan:
- WIDTH=4, in=1011, dir=0, op=0, amt=1 -> out_valid one edge after accept, out=0110, op_count=1 after handshake.
- in=1011, dir=1, amt=2: op=1 -> out=1110; op=0 -> out=0010; both out_valid exactly 2 edges after accept.
- in=0101, amt=0 -> out=0101, out_valid on the edge after accept, busy high for one cycle before the handshake.
- in=1000, dir=1, amt=9 (saturates to 4): op=1 -> out=1111 after 4 edges; op=0 -> out=0000; dir=0 -> out=0000.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in, in_valid and shift_amt -> out, out_valid and in_ready=0 unchanged; op_count increments once when out_ready=1.
- Reset and sweep:
  - Assert rst_n=0 during SHIFT -> out_valid=0, out=0, busy=0, in_ready=1, op_count=0 immediately.
  - Then sweep every in (0..15), dir 0/1, op 0/1, amt 0..5 -> out matches the combinational shifter for each case.
  - op_count wraps correctly after 256 operations.

Source files
------------

// File: rtl/seq_shift_unit.sv
// Sequential shift unit: moves the operand one bit position per clock and
// returns a result identical to the combinational n-bit shifter.
module seq_shift_unit #(
    parameter int WIDTH     = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in,
    input  logic                 shift_dir,
    input  logic                 op,
    input  logic [WIDTH-1:0]     shift_amt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] op_count
);

    // Step counter only needs to hold 0..WIDTH after saturation.
    localparam int                  AMT_BITS  = $clog2(WIDTH + 1);
    localparam logic [AMT_BITS-1:0] AMT_MAX   = AMT_BITS'(WIDTH);
    localparam logic [WIDTH:0]      WIDTH_EXT = (WIDTH + 1)'(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t                 state;
    logic [WIDTH-1:0]       result;
    logic [AMT_BITS-1:0]    cnt;
    logic                   dir_q;
    logic                   op_q;
    logic [CNT_WIDTH-1:0]   count_q;

    logic [AMT_BITS-1:0]    amt_sat;
    logic                   fill_bit;
    logic [WIDTH-1:0]       step_val;

    always_comb begin
        amt_sat = ({1'b0, shift_amt} >= WIDTH_EXT) ? AMT_MAX : shift_amt[AMT_BITS-1:0];
    end

    // Arithmetic right shifts replicate the MSB; everything else fills with zero.
    always_comb begin
        fill_bit = dir_q & op_q & result[WIDTH-1];
        if (dir_q) begin
            step_val = {fill_bit, result[WIDTH-1:1]};
        end else begin
            step_val = {result[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            result  <= '0;
            cnt     <= '0;
            dir_q   <= 1'b0;
            op_q    <= 1'b0;
            count_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        result <= in;
                        dir_q  <= shift_dir;
                        op_q   <= op;
                        cnt    <= amt_sat;
                        state  <= (amt_sat == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    result <= step_val;
                    cnt    <= cnt - AMT_BITS'(1);
                    if (cnt == AMT_BITS'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // A request arriving alongside out_ready waits for IDLE.
                    if (out_ready) begin
                        count_q <= count_q + CNT_WIDTH'(1);
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out       = result;
    assign op_count  = count_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Self-checking bench for seq_shift_unit: directed and randomized shifts
// compared against an arithmetic model of the combinational shifter.
module tb_seq_shift_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       shift_dir;
    logic       op;
    logic [3:0] shift_amt;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       busy;
    logic [7:0] op_count;

    int tests_run    = 0;
    int tests_failed = 0;
    int model_count  = 0;

    seq_shift_unit #(.WIDTH(4), .CNT_WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_data),
        .shift_dir (shift_dir),
        .op        (op),
        .shift_amt (shift_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out_data),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    // Combinational shifter behaviour expressed as plain integer arithmetic.
    function automatic logic [3:0] ref_shift(logic [3:0] a, logic d, logic o, logic [3:0] amt);
        int k;
        int v;
        k = (amt > 4) ? 4 : int'(amt);
        if (!d)
            v = int'(a) * (2 ** k);
        else if (o && a[3])
            v = (int'(a) - 16) >>> k;
        else
            v = int'(a) / (2 ** k);
        return v[3:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Accepts one request and waits (bounded) for the result to appear.
    task automatic startOp(input logic [3:0] a, input logic d, input logic o, input logic [3:0] amt);
        int edges;
        int k;
        k = (amt > 4) ? 4 : int'(amt);
        checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
        in_data   = a;
        shift_dir = d;
        op        = o;
        shift_amt = amt;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        in_data   = 4'($urandom_range(0, 15));
        shift_dir = 1'($urandom_range(0, 1));
        op        = 1'($urandom_range(0, 1));
        shift_amt = 4'($urandom_range(0, 15));
        edges = 0;
        while (!out_valid && edges < 20) begin
            tick();
            edges++;
        end
        checkOutput("latency", 32'(edges), 32'(k));
        checkOutput("out", 32'(out_data), 32'(ref_shift(a, d, o, amt)));
        checkOutput("busy_done", 32'(busy), 32'd1);
        checkOutput("in_ready_done", 32'(in_ready), 32'd0);
    endtask

    task automatic finishOp(input logic [3:0] expected);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        model_count = (model_count + 1) % 256;
        checkOutput("op_count", 32'(op_count), 32'(model_count));
        checkOutput("out_valid_clear", 32'(out_valid), 32'd0);
        checkOutput("out_hold", 32'(out_data), 32'(expected));
    endtask

    task automatic applyStimulus(input logic [3:0] a, input logic d, input logic o, input logic [3:0] amt);
        startOp(a, d, o, amt);
        finishOp(ref_shift(a, d, o, amt));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        shift_dir = 1'b0;
        op        = 1'b0;
        shift_amt = 4'h0;
        out_ready = 1'b0;
        #12;
        checkOutput("reset_out", 32'(out_data), 32'd0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_op_count", 32'(op_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        applyStimulus(4'b1011, 1'b0, 1'b0, 4'd1);
        applyStimulus(4'b1011, 1'b1, 1'b1, 4'd2);
        applyStimulus(4'b1011, 1'b1, 1'b0, 4'd2);
        applyStimulus(4'b0101, 1'b0, 1'b0, 4'd0);
        applyStimulus(4'b1000, 1'b1, 1'b1, 4'd9);
        applyStimulus(4'b1000, 1'b1, 1'b0, 4'd9);
        applyStimulus(4'b1000, 1'b0, 1'b1, 4'd9);
        applyStimulus(4'b0111, 1'b1, 1'b1, 4'd15);

        // Backpressure: result must hold while operands and requests churn.
        startOp(4'b1011, 1'b1, 1'b1, 4'd2);
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 4'($urandom_range(0, 15));
            shift_amt = 4'($urandom_range(0, 15));
            tick();
            checkOutput("bp_out", 32'(out_data), 32'b1110);
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b1;
        in_data   = 4'b0101;
        shift_dir = 1'b0;
        op        = 1'b0;
        shift_amt = 4'd0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        model_count = (model_count + 1) % 256;
        checkOutput("bp_op_count", 32'(op_count), 32'(model_count));
        checkOutput("bp_idle_in_ready", 32'(in_ready), 32'd1);
        checkOutput("bp_idle_out_valid", 32'(out_valid), 32'd0);
        checkOutput("bp_idle_out", 32'(out_data), 32'b1110);
        tick();
        in_valid = 1'b0;
        checkOutput("bp_next_out_valid", 32'(out_valid), 32'd1);
        checkOutput("bp_next_out", 32'(out_data), 32'b0101);
        finishOp(4'b0101);

        // Reset in the middle of a shift abandons it and clears the count.
        in_data   = 4'b1101;
        shift_dir = 1'b1;
        op        = 1'b1;
        shift_amt = 4'd3;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        tick();
        checkOutput("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_reset_out", 32'(out_data), 32'd0);
        checkOutput("mid_reset_busy", 32'(busy), 32'd0);
        checkOutput("mid_reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("mid_reset_op_count", 32'(op_count), 32'd0);
        model_count = 0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Exhaustive sweep; 384 operations also exercise the counter wrap.
        for (int a = 0; a < 16; a++)
            for (int d = 0; d < 2; d++)
                for (int o = 0; o < 2; o++)
                    for (int amt = 0; amt < 6; amt++)
                        applyStimulus(4'(a), 1'(d), 1'(o), 4'(amt));

        for (int i = 0; i < 40; i++)
            applyStimulus(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
